// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/redirect sequencer and the ID/EX stages.
package hazard_pkg;

    // Sequencer states; the encoding is visible on state_o for debug.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_REDIR = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_LW  = 6'b100011;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight register write tracker. Slot 0 holds the instruction that just left ID (now in
// EX); each cycle entries age by one slot and the oldest drops out. Only the slots whose
// write has not yet landed in the regfile are compared against the ID source registers.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 3,
    parameter int unsigned WB_SPLIT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load_valid,
    input  logic [4:0] load_addr,
    input  logic [4:0] rs_addr,
    input  logic [4:0] rt_addr,
    input  logic       uses_rs,
    input  logic       uses_rt,
    output logic       hazard
);

    // Slots at or beyond this index have completed their write in time for an ID read.
    localparam int unsigned CHK_DEPTH = SB_DEPTH - WB_SPLIT;

    logic [SB_DEPTH-1:0] slot_valid;
    logic [4:0]          slot_addr [SB_DEPTH];

    // Shift register: load slot 0, age everything else by one, clear asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slot_valid <= '0;
            for (int unsigned k = 0; k < SB_DEPTH; k++) begin
                slot_addr[k] <= REG_ZERO;
            end
        end else begin
            slot_valid[0] <= load_valid;
            slot_addr[0]  <= load_addr;
            for (int unsigned k = 1; k < SB_DEPTH; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_addr[k]  <= slot_addr[k-1];
            end
        end
    end

    // Parallel compare of every still-pending slot against the ID source registers.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            if ((k < CHK_DEPTH) && slot_valid[k] && (slot_addr[k] != REG_ZERO) &&
                ((uses_rs && (slot_addr[k] == rs_addr)) ||
                 (uses_rt && (slot_addr[k] == rt_addr)))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: stalls IF/ID on read-after-write hazards
// (no forwarding exists), flushes wrong-path instructions on taken branches/jumps, and
// clears the unreset pipeline registers after reset.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 3,
    parameter int unsigned WB_SPLIT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  rs_addr_D,
    input  logic [4:0]  rt_addr_D,
    input  logic        uses_rs_D,
    input  logic        uses_rt_D,
    input  logic        RegWriteD,
    input  logic [4:0]  wb_addr_D,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        ALUOutE0,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        PCSrcE,
    output logic [1:0]  state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    state_t state;
    logic   hazard;
    logic   active;
    logic   redirect;
    logic   sb_load_valid;

    // Redirects are only honoured in RUN/STALL; in REDIR the EX stage holds a bubble.
    assign active   = (state == ST_RUN) || (state == ST_STALL);
    assign redirect = active && ((BranchE && ALUOutE0) || JumpE);
    assign state_o  = state;

    // A flushed ID instruction never reaches EX, so it must not occupy the scoreboard.
    assign sb_load_valid = RegWriteD && (wb_addr_D != REG_ZERO) && !FlushE;

    hazard_scoreboard #(
        .SB_DEPTH (SB_DEPTH),
        .WB_SPLIT (WB_SPLIT)
    ) u_scoreboard (
        .CLK        (CLK),
        .RST        (RST),
        .load_valid (sb_load_valid),
        .load_addr  (wb_addr_D),
        .rs_addr    (rs_addr_D),
        .rt_addr    (rt_addr_D),
        .uses_rs    (uses_rs_D),
        .uses_rt    (uses_rt_D),
        .hazard     (hazard)
    );

    // Pipeline control outputs, decoded from state and the current redirect/hazard.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        PCSrcE = 1'b0;
        unique case (state)
            ST_INIT: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                // PC is held only once reset has been released.
                StallF = !RST;
            end
            ST_RUN, ST_STALL: begin
                if (redirect) begin
                    PCSrcE = 1'b1;
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (hazard) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            ST_REDIR: begin
            end
            default: begin
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_INIT;
        end else begin
            unique case (state)
                ST_INIT:          state <= ST_RUN;
                ST_RUN, ST_STALL: state <= redirect ? ST_REDIR : (hazard ? ST_STALL : ST_RUN);
                ST_REDIR:         state <= hazard ? ST_STALL : ST_RUN;
                default:          state <= ST_INIT;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters: hazard stall cycles and taken redirects.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (active && hazard && !redirect && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (WB_SPLIT=1 and WB_SPLIT=0) share stimulus and are
// compared against a directed vector table and a per-instance behavioural model.
// Counter checks apply only when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] rs_addr_D, rt_addr_D, wb_addr_D;
    logic       uses_rs_D, uses_rt_D, RegWriteD, BranchE, JumpE, ALUOutE0;

    logic       sf_a, sd_a, fd_a, fe_a, pc_a;
    logic [1:0] st_a;
    logic       sf_b, sd_b, fd_b, fe_b, pc_b;
    logic [1:0] st_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

    always #5 CLK = ~CLK;

    hazard_ctrl #(.SB_DEPTH(3), .WB_SPLIT(1)) u_dut (
        .CLK(CLK), .RST(RST), .rs_addr_D(rs_addr_D), .rt_addr_D(rt_addr_D),
        .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D), .RegWriteD(RegWriteD),
        .wb_addr_D(wb_addr_D), .BranchE(BranchE), .JumpE(JumpE), .ALUOutE0(ALUOutE0),
        .StallF(sf_a), .StallD(sd_a), .FlushD(fd_a), .FlushE(fe_a), .PCSrcE(pc_a),
        .state_o(st_a)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
`endif
    );

    hazard_ctrl #(.SB_DEPTH(3), .WB_SPLIT(0)) u_dut_ns (
        .CLK(CLK), .RST(RST), .rs_addr_D(rs_addr_D), .rt_addr_D(rt_addr_D),
        .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D), .RegWriteD(RegWriteD),
        .wb_addr_D(wb_addr_D), .BranchE(BranchE), .JumpE(JumpE), .ALUOutE0(ALUOutE0),
        .StallF(sf_b), .StallD(sd_b), .FlushD(fd_b), .FlushE(fe_b), .PCSrcE(pc_b),
        .state_o(st_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
`endif
    );

    // Output vector layout: {StallF, StallD, FlushD, FlushE, PCSrcE, state[1:0]}.
    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt, rw;
        logic [4:0] wb;
        logic       br, jmp, alu;
        logic [6:0] exp;
    } vec_t;

    localparam logic [6:0] E_INIT   = 7'b1011000;
    localparam logic [6:0] E_RST    = 7'b0011000;
    localparam logic [6:0] E_RUN    = 7'b0000001;
    localparam logic [6:0] E_STALL  = 7'b0000010;
    localparam logic [6:0] E_HZ_RUN = 7'b1101001;
    localparam logic [6:0] E_HZ_STL = 7'b1101010;
    localparam logic [6:0] E_REDIR  = 7'b0011101;
    localparam logic [6:0] E_INREDIR = 7'b0000011;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance: 0=init,1=run,2=stall,3=redir; pend[m][age] = dest reg or 0.
    int mode [2];
    int pend [2][3];
    int split [2];
    int stall_n [2];
    int flush_n [2];
    logic [6:0] oa, ob;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic rw, input logic [4:0] wb,
                          input logic br, input logic jmp, input logic alu);
        rs_addr_D = rs; rt_addr_D = rt; uses_rs_D = urs; uses_rt_D = urt;
        RegWriteD = rw; wb_addr_D = wb; BranchE = br; JumpE = jmp; ALUOutE0 = alu;
    endtask

    function automatic vec_t mk(input int rs, input int rt, input int urs, input int urt,
                                input int rw, input int wb, input int br, input int jmp,
                                input int alu, input logic [6:0] exp);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1'(urs); v.urt = 1'(urt); v.rw = 1'(rw);
        v.wb = 5'(wb); v.br = 1'(br); v.jmp = 1'(jmp); v.alu = 1'(alu); v.exp = exp;
        return v;
    endfunction

    function automatic logic model_hz(input int m);
        logic h = 1'b0;
        for (int k = 0; k < 3 - split[m]; k++) begin
            if (pend[m][k] != 0 &&
                ((uses_rs_D && pend[m][k] == int'(rs_addr_D)) ||
                 (uses_rt_D && pend[m][k] == int'(rt_addr_D))))
                h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic model_redir();
        return (BranchE && ALUOutE0) || JumpE;
    endfunction

    function automatic logic [6:0] model_out(input int m);
        logic [1:0] st = 2'(mode[m]);
        if (mode[m] == 0) return {5'b10110, st};
        if (mode[m] == 3) return {5'b00000, st};
        if (model_redir()) return {5'b00111, st};
        if (model_hz(m)) return {5'b11010, st};
        return {5'b00000, st};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mode[m] = 0;
            stall_n[m] = 0;
            flush_n[m] = 0;
            for (int k = 0; k < 3; k++) pend[m][k] = 0;
        end
    endtask

    // Advance one model by a clock edge, using the outputs it predicted for this cycle.
    task automatic model_step(input int m, input logic [6:0] o);
        logic h = model_hz(m);
        logic r = model_redir();
        int nxt;
        if (mode[m] == 0) nxt = 1;
        else if (mode[m] == 3) nxt = h ? 2 : 1;
        else begin
            nxt = r ? 3 : (h ? 2 : 1);
            if (r) flush_n[m]++;
            else if (h) stall_n[m]++;
        end
        for (int k = 2; k > 0; k--) pend[m][k] = pend[m][k-1];
        pend[m][0] = (o[3] || !RegWriteD) ? 0 : int'(wb_addr_D);
        mode[m] = nxt;
    endtask

    // Inputs are already driven at posedge+1; sample at the falling edge, then clock.
    task automatic step(input string tag, input logic use_exp, input logic [6:0] exp);
        logic [6:0] ea, eb;
        #4;
        ea = model_out(0);
        eb = model_out(1);
        oa = {sf_a, sd_a, fd_a, fe_a, pc_a, st_a};
        ob = {sf_b, sd_b, fd_b, fe_b, pc_b, st_b};
        if (use_exp) check({tag, " table"}, 32'(oa), 32'(exp));
        check({tag, " model_split1"}, 32'(oa), 32'(ea));
        check({tag, " model_split0"}, 32'(ob), 32'(eb));
        @(posedge CLK);
        model_step(0, ea);
        model_step(1, eb);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        check("in_reset_a", 32'({sf_a, sd_a, fd_a, fe_a, pc_a, st_a}), 32'(E_RST));
        check("in_reset_b", 32'({sf_b, sd_b, fd_b, fe_b, pc_b, st_b}), 32'(E_RST));
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_reset", {scnt_a | fcnt_a | scnt_b | fcnt_b}, 32'd0);
`endif
        RST = 1'b0;
        model_reset();
    endtask

    vec_t tbl [$];

    initial begin
        int cnt_a, cnt_b;
        logic done;

        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8, 0, 0, 0, E_RUN));      // lw $8
        tbl.push_back(mk(8, 0, 1, 0, 1, 9, 0, 0, 0, E_HZ_RUN));   // reads $8
        tbl.push_back(mk(8, 0, 1, 0, 1, 9, 0, 0, 0, E_HZ_STL));
        tbl.push_back(mk(8, 0, 1, 0, 1, 9, 0, 0, 0, E_STALL));    // $8 in WB slot: go
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, E_RUN));      // writes $0
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, E_RUN));      // reads $0
        tbl.push_back(mk(0, 0, 0, 0, 1, 10, 1, 0, 1, E_REDIR));   // taken beq
        tbl.push_back(mk(0, 0, 0, 0, 1, 11, 1, 0, 1, E_INREDIR)); // blocked back-to-back
        tbl.push_back(mk(0, 11, 0, 1, 1, 12, 0, 1, 0, E_REDIR));  // jump + hazard on $11
        tbl.push_back(mk(0, 12, 0, 1, 0, 0, 0, 0, 0, E_INREDIR)); // $12 was flushed
        tbl.push_back(mk(12, 0, 1, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_RUN));      // untaken beq
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0, 0, E_RUN));
        tbl.push_back(mk(3, 5, 1, 1, 0, 0, 0, 0, 0, E_HZ_RUN));   // rt dependency
        tbl.push_back(mk(3, 5, 1, 1, 0, 0, 0, 0, 0, E_HZ_STL));
        tbl.push_back(mk(3, 5, 1, 1, 0, 0, 0, 0, 0, E_STALL));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 0, 0, 0, E_RUN));
        tbl.push_back(mk(7, 7, 0, 0, 0, 0, 0, 0, 0, E_RUN));      // match but not used
        tbl.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 0, E_RUN));
        tbl.push_back(mk(4, 0, 1, 0, 0, 0, 0, 1, 0, E_REDIR));    // jump beats hazard
        tbl.push_back(mk(4, 0, 1, 0, 0, 0, 0, 0, 0, E_INREDIR));  // hazard seen in REDIR
        tbl.push_back(mk(4, 0, 1, 0, 0, 0, 0, 0, 0, E_STALL));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].rw, tbl[i].wb,
                   tbl[i].br, tbl[i].jmp, tbl[i].alu);
            step($sformatf("vec%0d", i), 1'b1, tbl[i].exp);
        end

        // Stall length for one lw -> dependent add, per WB_SPLIT setting.
        do_reset();
        step("dep_init", 1'b1, E_INIT);
        set_in(0, 0, 0, 0, 1, 8, 0, 0, 0);
        step("dep_lw", 1'b1, E_RUN);
        set_in(8, 0, 1, 0, 0, 0, 0, 0, 0);
        cnt_a = 0;
        cnt_b = 0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            step("dep_hold", 1'b0, '0);
            if (oa[5]) cnt_a++;
            if (ob[5]) cnt_b++;
            done = !oa[5] && !ob[5];
        end
        check("dep_done", 32'(done), 32'd1);
        check("dep_stalls_split1", cnt_a, 32'd2);
        check("dep_stalls_split0", cnt_b, 32'd3);
`ifdef HAZARD_PERF_CNT_EN
        check("dep_stall_cnt_split1", scnt_a, 32'd2);
        check("dep_stall_cnt_split0", scnt_b, 32'd3);
`endif

        // Reset mid-stall: immediate INIT and scoreboard cleared.
        do_reset();
        step("mid_init", 1'b1, E_INIT);
        set_in(0, 0, 0, 0, 1, 9, 0, 0, 0);
        step("mid_lw", 1'b1, E_RUN);
        set_in(9, 0, 1, 0, 0, 0, 0, 0, 0);
        step("mid_hz", 1'b1, E_HZ_RUN);
        RST = 1'b1;
        #1;
        check("mid_rst_a", 32'({sf_a, sd_a, fd_a, fe_a, pc_a, st_a}), 32'(E_RST));
        check("mid_rst_b", 32'({sf_b, sd_b, fd_b, fe_b, pc_b, st_b}), 32'(E_RST));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        step("mid_post_init", 1'b1, E_INIT);
        step("mid_post_run", 1'b1, E_RUN);  // still reading $9: entry was cleared

        // Randomised run against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, 1'($urandom));
            step("rand", 1'b0, '0);
        end
`ifdef HAZARD_PERF_CNT_EN
        check("rand_stall_cnt_a", scnt_a, 32'(stall_n[0]));
        check("rand_flush_cnt_a", fcnt_a, 32'(flush_n[0]));
        check("rand_stall_cnt_b", scnt_b, 32'(stall_n[1]));
        check("rand_flush_cnt_b", fcnt_b, 32'(flush_n[1]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        split[0] = 1;
        split[1] = 0;
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core.
- Tracks in-flight register writes in a scoreboard and stalls IF/ID on read-after-write hazards; the core has no forwarding paths.
- Resolves taken branches and jumps reported by EX_stage and flushes wrong-path instructions.
- Clears the pipeline registers after reset, since they have no reset of their own.

Parameters:
- SB_DEPTH, 3, number of stages between ID and regfile write completion (EX, MEM, WB).
- WB_SPLIT, 1, 1 = regfile writes in first half-cycle, so the WB slot never causes a stall.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- rs_addr_D  in  5  rs field of instruction in ID.
- rt_addr_D  in  5  rt field of instruction in ID.
- uses_rs_D  in  1  ID instruction reads rs.
- uses_rt_D  in  1  ID instruction reads rt.
- RegWriteD  in  1  ID instruction writes regfile.
- wb_addr_D  in  5  ID destination (rt/rd/31 already selected).
- BranchE  in  1  EX holds beq/bne.
- JumpE  in  1  EX holds j/jal/jr.
- ALUOutE0  in  1  bit 0 of EX ALUOut (branch-taken flag).
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- FlushD  out  1  clear IF/ID to nop.
- FlushE  out  1  insert bubble into ID/EX (all control 0).
- PCSrcE  out  1  select EX branch/jump target for next PC.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- States: INIT(0), RUN(1), STALL(2), REDIR(3).
- Reset asserted: state=INIT, scoreboard cleared, all outputs 0 except FlushD=FlushE=1 (combinational from INIT).
- INIT: lasts exactly 1 cycle after RST deasserts; FlushD=FlushE=1, StallF=1; then RUN.
- redirect = (BranchE & ALUOutE0) | JumpE; evaluated in RUN/STALL.
- hazard = any valid scoreboard slot k, for k < SB_DEPTH-WB_SPLIT, with nonzero addr equal to rs_addr_D (when uses_rs_D) or rt_addr_D (when uses_rt_D). Register 0 never hazards.
- Priority: redirect > hazard; the ID instruction is wrong-path on a redirect.
- On redirect (combinational, same cycle): PCSrcE=1, FlushD=1, FlushE=1, StallF=StallD=0. Next state REDIR.
- REDIR: 1 cycle, all outputs 0. It blocks a back-to-back redirect, since EX now holds a bubble. Next state RUN, or STALL if hazard.
- On hazard without redirect (combinational): StallF=StallD=1, FlushE=1. Next state STALL while hazard persists, else RUN.
- RUN/STALL with neither condition: all outputs 0; state RUN.
- Scoreboard: SB_DEPTH-entry shift register of {valid, addr[4:0]}, shifted every cycle.
- Slot0 is loaded with {RegWriteD & wb_addr_D!=0, wb_addr_D} when no FlushE this cycle; otherwise slot0 is loaded with invalid.
- The oldest slot drops out.
- On a redirect, slot0 (the ID instruction being flushed) is loaded invalid. Existing slots are kept; the EX branch/jal entry is legal.
- Worst-case stall: SB_DEPTH-WB_SPLIT cycles (lw followed by dependent add: 2 cycles with defaults).
- RST mid-operation: immediate return to INIT, scoreboard cleared asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0], reset to 0.
- stall_cnt increments each cycle hazard causes a stall; flush_cnt increments each redirect.
- Both counters saturate at 32'hFFFFFFFF.
- When undefined: no counters and no extra ports; all other behaviour identical.

Decomposition:
- Shared package hazard_pkg holds:
  - state encodings ST_INIT/ST_RUN/ST_STALL/ST_REDIR;
  - REG_ZERO=5'd0 and REG_RA=5'd31;
  - opcode constants OP_JAL=6'b000011 and OP_LW=6'b100011, shared with the ID/EX stages.
- One natural sub-module: hazard_scoreboard (shift register plus parallel compare, outputs hazard).

Test Plan:
- Reset release: RST high 3 cycles then low -> FlushD=FlushE=StallF=1 for exactly 1 cycle, state_o=0 then 1.
- Dependency: lw $8 issued (RegWriteD=1, wb_addr_D=8), next ID reads rs=8 -> StallF/StallD/FlushE=1 for 2 cycles, then 0 and state_o=1.
- Register zero: writer to $0 followed by reader of $0 -> no stall ever.
- Taken beq: BranchE=1, ALUOutE0=1 -> PCSrcE=FlushD=FlushE=1 same cycle, next cycle state_o=3 with all outputs 0.
- Simultaneous redirect and hazard: JumpE=1 while ID reads a pending reg -> redirect outputs only (StallF=0), and the flushed instruction is not entered into the scoreboard.
- WB_SPLIT=0: hazard persists 3 cycles for the same dependency; with HAZARD_PERF_CNT_EN, stall_cnt=3 afterward.
